bmem_line_arbiter: RTL and testbench
====================================

# bmem_line_arbiter

Shares the single banked-memory port between the instruction cache and the data cache of `pipeline_cpu`. It accepts whole-line (256-bit) read requests from the I-cache and read/write requests from the D-cache. It arbitrates round-robin between them and sequences each request into the bmem protocol: one-cycle read command then a 4-beat response, or a 4-beat write burst. It sits at the cpu top level between the two caches and the `bmem_*` ports, with exactly one memory transaction in flight at a time.

## Interface
- ADDR_WIDTH, 32, byte address width
- BEAT_WIDTH, 64, bmem data beat width
- BURST_LEN, 4, beats per line; line width = BEAT_WIDTH*BURST_LEN = 256
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_addr  in  ADDR_WIDTH  I-cache line address; bits [4:0] ignored
- i_read  in  1  I-cache read request, held until i_resp
- i_rdata  out  256  returned line, beat k in bits [64k+63:64k]
- i_resp  out  1  one-cycle completion pulse
- d_addr  in  ADDR_WIDTH  D-cache line address; bits [4:0] ignored
- d_read  in  1  D-cache read request, held until d_resp
- d_write  in  1  D-cache writeback request, held until d_resp
- d_wdata  in  256  writeback line, stable while d_write is high
- d_rdata  out  256  returned line
- d_resp  out  1  one-cycle completion pulse
- bmem_addr  out  ADDR_WIDTH  line address {addr[31:5],5'b0}
- bmem_read  out  1  read command
- bmem_write  out  1  write beat valid
- bmem_wdata  out  BEAT_WIDTH  write beat
- bmem_ready  in  1  memory accepts the command or beat this cycle
- bmem_raddr  in  ADDR_WIDTH  address tag of the returning beat
- bmem_rdata  in  BEAT_WIDTH  returning beat
- bmem_rvalid  in  1  returning beat valid

## Operation
- States: IDLE, RD_CMD, RD_DATA, WR_BURST, DONE.
- IDLE: sample requests. With one requester, grant it. With both, grant the port not granted last. The last-grant pointer resets to I, so D wins the first tie. Latch the port, the aligned address and, for a write, d_wdata. If d_read and d_write are both high, treat it as a write. Go to RD_CMD or WR_BURST.
- RD_CMD: bmem_read=1, bmem_addr=latched address. Move to RD_DATA on the cycle read&&ready is true.
- RD_DATA: accept a beat when bmem_rvalid=1 and bmem_raddr equals the latched address. Store beat k into line bits [64k+63:64k], with k counting 0..BURST_LEN-1. Ignore beats whose tag does not match. After the last beat, go to DONE.
- WR_BURST: bmem_write=1, bmem_addr held, bmem_wdata = latched line beat k. k advances only on write&&ready. After beat BURST_LEN-1 is accepted, go to DONE.
- DONE: pulse resp for the granted port for one cycle and update the last-grant pointer. The other port's request is not considered this cycle. Return to IDLE.
- i_rdata/d_rdata are driven from a per-port register. It is loaded only on that port's read completion and holds its value otherwise, including across other-port transactions.
- Requesters are not required to deassert early, but must not change addr/wdata while the request is high.
- Beat counter is clog2(BURST_LEN) bits and wraps to 0 on completion.

## Timing
- Reset (asserted asynchronously): state=IDLE, all bmem outputs and resps 0, bmem_addr 0, bmem_wdata 0, rdata registers 0, counter 0, last-grant=I. Effect is immediate, even mid-burst. Beats arriving after reset are ignored because IDLE ignores bmem_rvalid.
- All outputs are registered or decoded from state and latched registers. There is no combinational path from any input to any output.
- Read latency: request seen in IDLE at cycle 0; bmem_read high from cycle 1; resp = (cycle of last beat)+1.
- Write latency with ready always high: request at cycle 0; beats on cycles 1-4; resp on cycle 5.
- Minimum gap: a request pending while another completes starts its command 2 cycles after the other's resp (DONE -> IDLE -> CMD).
- bmem_ready low stalls RD_CMD or the current write beat indefinitely, with outputs held.
- rvalid in RD_CMD, WR_BURST, DONE or IDLE is ignored.

## Test plan
- I read, addr 0x0000_1044, memory returns beats 0x11..,0x22..,0x33..,0x44.. -> bmem_addr 0x0000_1040 and read for 1 cycle. i_resp pulses exactly once, i_rdata[63:0]=beat0 and [255:192]=beat3.
- D write, addr 0x8000_0020, ready always 1 -> bmem_write high exactly 4 cycles carrying d_wdata[63:0..255:192] in order. d_resp on cycle 5. No bmem_read.
- I and D request in the same cycle after reset -> D served first, then I. The next tie goes to D again because the last grant was I.
- bmem_ready low for 3 cycles during RD_CMD and during write beat 2 -> command and beat held stable. Beat not repeated, total 4 write beats.
- Mismatched bmem_raddr beat interleaved mid-read -> ignored, line assembled from the matching beats only.
- rst_n asserted during beat 2 of a write -> bmem_write drops immediately, no resp. After release, a new D read completes normally.

Source files
------------

// File: rtl/bmem_line_arbiter_if.sv
// Banked-memory port bundle: line-address command and write-beat channel
// toward memory, tagged read-beat channel back from it.
interface bmem_line_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int BEAT_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0] bmem_addr;
    logic                  bmem_read;
    logic                  bmem_write;
    logic [BEAT_WIDTH-1:0] bmem_wdata;
    logic                  bmem_ready;
    logic [ADDR_WIDTH-1:0] bmem_raddr;
    logic [BEAT_WIDTH-1:0] bmem_rdata;
    logic                  bmem_rvalid;

    modport master (
        output bmem_addr, bmem_read, bmem_write, bmem_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );

    modport slave (
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );
endinterface

// File: rtl/bmem_line_arbiter.sv
// Round-robin arbiter sharing one banked-memory port between the I-cache and
// D-cache; one whole-line read or write transaction in flight at a time.
module bmem_line_arbiter #(
    parameter  int ADDR_WIDTH = 32,
    parameter  int BEAT_WIDTH = 64,
    parameter  int BURST_LEN  = 4,
    localparam int LINE_WIDTH = BEAT_WIDTH * BURST_LEN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] i_addr_i,
    input  logic                  i_read_i,
    output logic [LINE_WIDTH-1:0] i_rdata_o,
    output logic                  i_resp_o,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic                  d_read_i,
    input  logic                  d_write_i,
    input  logic [LINE_WIDTH-1:0] d_wdata_i,
    output logic [LINE_WIDTH-1:0] d_rdata_o,
    output logic                  d_resp_o,
    bmem_line_arbiter_if.master   bmem
);
    localparam int               CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int               OFFS      = $clog2(LINE_WIDTH / 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {IDLE, RD_CMD, RD_DATA, WR_BURST, DONE} state_e;
    typedef enum logic {PORT_I, PORT_D} port_e;

    state_e                state_q,   state_d;
    port_e                 port_q,    port_d;
    port_e                 last_q,    last_d;
    logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic [LINE_WIDTH-1:0] line_q,    line_d;
    logic [LINE_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;

    logic req_i;
    logic req_d;
    logic grant_d;
    logic beat_hit;
    logic last_beat;
    logic unused_addr_bits;

    assign req_i     = i_read_i;
    assign req_d     = d_read_i | d_write_i;
    // D wins a tie unless it was the most recent grant.
    assign grant_d   = req_d & (~req_i | (last_q == PORT_I));
    assign beat_hit  = bmem.bmem_rvalid & (bmem.bmem_raddr == addr_q);
    assign last_beat = (cnt_q == LAST_BEAT);

    // Byte-offset bits inside a line carry no information for the memory.
    assign unused_addr_bits = ^{i_addr_i[OFFS-1:0], d_addr_i[OFFS-1:0]};

    always_comb begin
        // NOTE: every next-state variable gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        port_d    = port_q;
        last_d    = last_q;
        addr_d    = addr_q;
        line_d    = line_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (grant_d) begin
                    port_d = PORT_D;
                    addr_d = {d_addr_i[ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}};
                    if (d_write_i) begin
                        line_d  = d_wdata_i;
                        state_d = WR_BURST;
                    end else begin
                        state_d = RD_CMD;
                    end
                end else if (req_i) begin
                    port_d  = PORT_I;
                    addr_d  = {i_addr_i[ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}};
                    state_d = RD_CMD;
                end
            end

            RD_CMD: begin
                if (bmem.bmem_ready) state_d = RD_DATA;
            end

            RD_DATA: begin
                if (beat_hit) begin
                    // NOTE: blocking assignment in always_comb, so the port register below sees the final beat already merged.
                    line_d[int'(cnt_q) * BEAT_WIDTH +: BEAT_WIDTH] = bmem.bmem_rdata;
                    if (last_beat) begin
                        cnt_d   = '0;
                        state_d = DONE;
                        if (port_q == PORT_I) i_rdata_d = line_d;
                        else                  d_rdata_d = line_d;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            WR_BURST: begin
                if (bmem.bmem_ready) begin
                    if (last_beat) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            DONE: begin
                last_d  = port_q;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments; the line registers are reset too because their contents are visible on the rdata ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            port_q    <= PORT_I;
            last_q    <= PORT_I;
            addr_q    <= '0;
            line_q    <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            port_q    <= port_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            line_q    <= line_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bmem.bmem_addr  = addr_q;
    assign bmem.bmem_read  = (state_q == RD_CMD);
    assign bmem.bmem_write = (state_q == WR_BURST);
    assign bmem.bmem_wdata = (state_q == WR_BURST)
                           ? line_q[int'(cnt_q) * BEAT_WIDTH +: BEAT_WIDTH] : '0;

    assign i_resp_o  = (state_q == DONE) && (port_q == PORT_I);
    assign d_resp_o  = (state_q == DONE) && (port_q == PORT_D);
    assign i_rdata_o = i_rdata_q;
    assign d_rdata_o = d_rdata_q;
endmodule

// File: tb/tb_bmem_line_arbiter.sv
// Directed bench for bmem_line_arbiter: a vector table of single transactions
// plus hand-written tie, gap and mid-burst reset sequences.
module tb_bmem_line_arbiter;
    logic         clk;
    logic         rst_n;
    logic [31:0]  i_addr, d_addr;
    logic         i_read, d_read, d_write;
    logic [255:0] d_wdata, i_rdata, d_rdata;
    logic         i_resp, d_resp;

    int total = 0;
    int bad   = 0;

    bmem_line_arbiter_if #(.ADDR_WIDTH(32), .BEAT_WIDTH(64)) bus ();

    bmem_line_arbiter #(.ADDR_WIDTH(32), .BEAT_WIDTH(64), .BURST_LEN(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_addr_i  (i_addr),
        .i_read_i  (i_read),
        .i_rdata_o (i_rdata),
        .i_resp_o  (i_resp),
        .d_addr_i  (d_addr),
        .d_read_i  (d_read),
        .d_write_i (d_write),
        .d_wdata_i (d_wdata),
        .d_rdata_o (d_rdata),
        .d_resp_o  (d_resp),
        .bmem      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         ir, dr, dw;
        logic [31:0]  addr;
        logic [255:0] line;
        int           junk_at, stall;
        logic [31:0]  exp_addr;
        int           exp_port, exp_lat, exp_rd, exp_wr;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Plays the memory for one transaction until a resp is seen; drops the
    // request of whichever port responded.
    task automatic serve(input logic [255:0] rline, input logic [255:0] wline,
                         input int junk_at, input int stall,
                         output logic [31:0] got_addr, output int got_port, output int lat,
                         output int rd_hi, output int wr_hi);
        int beat, wacc, stall_left;
        bit seen, trig, cmd_acc, junk_done;
        beat = 0; wacc = 0; stall_left = stall;
        seen = 1'b0; trig = 1'b0; cmd_acc = 1'b0; junk_done = 1'b0;
        got_addr = '0; got_port = 0; lat = 0; rd_hi = 0; wr_hi = 0;
        for (int c = 1; c <= 40 && got_port == 0; c++) begin
            @(negedge clk);
            bus.bmem_rvalid = 1'b0;
            if (bus.bmem_read || bus.bmem_write) begin
                if (seen) check("bmem_addr stable", bus.bmem_addr, got_addr);
                else begin
                    got_addr = bus.bmem_addr;
                    seen     = 1'b1;
                end
            end
            if (bus.bmem_read) begin
                rd_hi++;
                trig = 1'b1;
            end
            if (bus.bmem_write) begin
                wr_hi++;
                check($sformatf("write beat %0d", wacc), bus.bmem_wdata, wline[wacc*64 +: 64]);
                if (wacc == 2) trig = 1'b1;
            end
            if (trig && stall_left > 0) begin
                bus.bmem_ready = 1'b0;
                stall_left--;
            end else begin
                bus.bmem_ready = 1'b1;
            end
            if (bus.bmem_write && bus.bmem_ready) wacc++;
            if (cmd_acc && beat < 4) begin
                bus.bmem_rvalid = 1'b1;
                if (beat == junk_at && !junk_done) begin
                    bus.bmem_raddr = got_addr ^ 32'h40;
                    bus.bmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
                    junk_done      = 1'b1;
                end else begin
                    bus.bmem_raddr = got_addr;
                    bus.bmem_rdata = rline[beat*64 +: 64];
                    beat++;
                end
            end
            if (bus.bmem_read && bus.bmem_ready) cmd_acc = 1'b1;
            if (i_resp) begin
                got_port = 1;
                lat      = c;
                i_read   = 1'b0;
            end
            if (d_resp) begin
                got_port += 2;
                lat      = c;
                d_read   = 1'b0;
                d_write  = 1'b0;
            end
        end
        bus.bmem_rvalid = 1'b0;
        bus.bmem_ready  = 1'b1;
    endtask

    task automatic post_resp(input string name);
        @(negedge clk);
        check({name, " i_resp single"}, i_resp, 1'b0);
        check({name, " d_resp single"}, d_resp, 1'b0);
    endtask

    logic [255:0] la, lb, lc, ld, le, lf, lt, lr;
    logic [255:0] exp_i_line, exp_d_line;
    logic [31:0]  got_addr;
    int           got_port, lat, rd_hi, wr_hi;

    initial begin
        la = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        lb = {64'hD3D3_D3D3_D3D3_D3D3, 64'hC2C2_C2C2_C2C2_C2C2, 64'hB1B1_B1B1_B1B1_B1B1, 64'hA0A0_A0A0_A0A0_A0A0};
        lc = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777, 64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};
        ld = {64'h3132_3334_3536_3738, 64'h2122_2324_2526_2728, 64'h1112_1314_1516_1718, 64'h0102_0304_0506_0708};
        le = {64'hF0F0_0000_0000_0004, 64'hF0F0_0000_0000_0003, 64'hF0F0_0000_0000_0002, 64'hF0F0_0000_0000_0001};
        lf = {64'h0BAD_0000_0000_0DDD, 64'h0BAD_0000_0000_0CCC, 64'h0BAD_0000_0000_0BBB, 64'h0BAD_0000_0000_0AAA};
        lt = {64'h7A7A_0000_0000_0004, 64'h7A7A_0000_0000_0003, 64'h7A7A_0000_0000_0002, 64'h7A7A_0000_0000_0001};
        lr = {64'h9E9E_0000_0000_0004, 64'h9E9E_0000_0000_0003, 64'h9E9E_0000_0000_0002, 64'h9E9E_0000_0000_0001};

        //            ir    dr    dw    addr          line junk stall exp_addr     port lat rd wr
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_1044, la,  -1,  0,   32'h0000_1040, 1,   6,  1, 0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h8000_0020, lb,  -1,  0,   32'h8000_0020, 2,   5,  0, 4};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0000_ABFF, lc,   2,  0,   32'h0000_ABE0, 2,   7,  1, 0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h1234_5678, ld,  -1,  3,   32'h1234_5660, 1,   9,  4, 0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, le,  -1,  3,   32'hFFFF_FFE0, 2,   8,  0, 7};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 32'h0000_0040, lf,  -1,  0,   32'h0000_0040, 2,   5,  0, 4};

        rst_n = 1'b0;
        i_addr = '0; d_addr = '0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
        bus.bmem_ready = 1'b1; bus.bmem_rvalid = 1'b0; bus.bmem_raddr = '0; bus.bmem_rdata = '0;
        exp_i_line = '0; exp_d_line = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset bmem_read",  bus.bmem_read,  1'b0);
        check("reset bmem_write", bus.bmem_write, 1'b0);
        check("reset bmem_addr",  bus.bmem_addr,  32'h0);
        check("reset bmem_wdata", bus.bmem_wdata, 64'h0);
        check("reset i_resp",     i_resp,         1'b0);
        check("reset d_resp",     d_resp,         1'b0);
        check("reset i_rdata",    i_rdata,        256'h0);
        check("reset d_rdata",    d_rdata,        256'h0);

        // Tie right after reset: D first, then I, command two cycles after D's resp.
        i_addr = 32'h0000_2000; i_read = 1'b1;
        d_addr = 32'h0000_3000; d_wdata = lt; d_write = 1'b1;
        serve(la, lt, -1, 0, got_addr, got_port, lat, rd_hi, wr_hi);
        check("tie1 first port", got_port, 2);
        check("tie1 first addr", got_addr, 32'h0000_3000);
        check("tie1 first wr beats", wr_hi, 4);
        post_resp("tie1 first");
        serve(la, lt, -1, 0, got_addr, got_port, lat, rd_hi, wr_hi);
        check("tie1 second port", got_port, 1);
        check("tie1 second addr", got_addr, 32'h0000_2000);
        check("tie1 second lat (gap)", lat, 6);
        exp_i_line = la;
        check("tie1 i_rdata", i_rdata, exp_i_line);
        post_resp("tie1 second");

        // Second tie: last grant was I, so D again.
        i_read = 1'b1; d_read = 1'b1;
        serve(lr, lt, -1, 0, got_addr, got_port, lat, rd_hi, wr_hi);
        check("tie2 first port", got_port, 2);
        check("tie2 first addr", got_addr, 32'h0000_3000);
        exp_d_line = lr;
        check("tie2 d_rdata", d_rdata, exp_d_line);
        check("tie2 i_rdata held", i_rdata, exp_i_line);
        post_resp("tie2 first");
        serve(lc, lt, -1, 0, got_addr, got_port, lat, rd_hi, wr_hi);
        check("tie2 second port", got_port, 1);
        exp_i_line = lc;
        check("tie2 i_rdata", i_rdata, exp_i_line);
        check("tie2 d_rdata held", d_rdata, exp_d_line);
        post_resp("tie2 second");

        for (int i = 0; i < NV; i++) begin
            i_read = vecs[i].ir; d_read = vecs[i].dr; d_write = vecs[i].dw;
            if (vecs[i].ir) i_addr = vecs[i].addr;
            else            d_addr = vecs[i].addr;
            d_wdata = vecs[i].line;
            serve(vecs[i].line, vecs[i].line, vecs[i].junk_at, vecs[i].stall,
                  got_addr, got_port, lat, rd_hi, wr_hi);
            if (vecs[i].exp_port == 1)  exp_i_line = vecs[i].line;
            else if (!vecs[i].dw)       exp_d_line = vecs[i].line;
            check($sformatf("v%0d bmem_addr", i), got_addr, vecs[i].exp_addr);
            check($sformatf("v%0d resp port", i), got_port, vecs[i].exp_port);
            check($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d read cycles", i), rd_hi, vecs[i].exp_rd);
            check($sformatf("v%0d write cycles", i), wr_hi, vecs[i].exp_wr);
            check($sformatf("v%0d i_rdata", i), i_rdata, exp_i_line);
            check($sformatf("v%0d d_rdata", i), d_rdata, exp_d_line);
            post_resp($sformatf("v%0d", i));
        end

        // Reset while write beat 2 is on the bus.
        d_addr = 32'h0000_0500; d_wdata = lb; d_write = 1'b1;
        repeat (3) @(negedge clk);
        check("rst beat2 before reset", bus.bmem_wdata, lb[191:128]);
        #2 rst_n = 1'b0;
        #1;
        check("rst bmem_write drop", bus.bmem_write, 1'b0);
        check("rst bmem_addr",       bus.bmem_addr,  32'h0);
        check("rst bmem_wdata",      bus.bmem_wdata, 64'h0);
        check("rst d_resp",          d_resp,         1'b0);
        check("rst i_rdata",         i_rdata,        256'h0);
        check("rst d_rdata",         d_rdata,        256'h0);
        d_write = 1'b0;
        exp_i_line = '0; exp_d_line = '0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.bmem_rvalid = 1'b1; bus.bmem_raddr = 32'h0000_0500; bus.bmem_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("post-rst%0d resp", c), {i_resp, d_resp}, 2'b00);
            check($sformatf("post-rst%0d bus", c), {bus.bmem_read, bus.bmem_write}, 2'b00);
        end
        bus.bmem_rvalid = 1'b0;
        d_addr = 32'h0000_0610; d_read = 1'b1;
        serve(lr, lb, -1, 0, got_addr, got_port, lat, rd_hi, wr_hi);
        exp_d_line = lr;
        check("post-rst read port", got_port, 2);
        check("post-rst read addr", got_addr, 32'h0000_0600);
        check("post-rst read lat",  lat, 6);
        check("post-rst d_rdata",   d_rdata, exp_d_line);
        check("post-rst i_rdata",   i_rdata, exp_i_line);
        post_resp("post-rst read");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
